// File: rtl/multicycle_adder.sv
// rtl/multicycle_adder.sv - chunk-serial adder/subtractor with valid/ready handshake
// Adds CHUNK bits per cycle over WIDTH/CHUNK cycles; outputs are registers only.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] sum_d;
  logic             last_chunk;

  // Select the active chunk and merge its result into the running sum
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    sum_d = sum_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        sum_d[i*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
      end
    end
    last_chunk = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry_q    <= sub ? 1'b1 : cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ADD;
          end
        end
        ADD: begin
          sum_q   <= sum_d;
          carry_q <= chunk_res[CHUNK];
          if (last_chunk) begin
            cout_q      <= chunk_res[CHUNK];
            ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 Parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK >= 1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; used in add mode only.
REQ-010 sub  input  1  0 = A+B+cin; 1 = A-B (A + ~B + 1), with cin ignored.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 sum  output  WIDTH  result, low WIDTH bits.
REQ-014 cout  output  1  carry out of bit WIDTH-1; in sub mode, 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 Accept: in IDLE, in_valid=1 SHALL register a, b (inverted if sub=1), and effective carry (sub ? 1 : cin), then move to ADD; with in_valid=0 the FSM SHALL stay in IDLE.
REQ-019 ADD SHALL run N = WIDTH/CHUNK cycles, cycle i (0..N-1) adding chunk i (bits i*CHUNK+CHUNK-1 .. i*CHUNK) plus the registered carry from chunk i-1, chunk 0 using the effective carry.
REQ-020 Each ADD cycle SHALL write its chunk result into the sum register and update the carry register; a chunk counter SHALL count 0..N-1 and move to DONE after chunk N-1.
REQ-021 Latency: accept on edge T SHALL give out_valid=1 after edge T+N, i.e. N+1 cycles after the accepting cycle (N=1 when CHUNK=WIDTH).
REQ-022 On entry to DONE, cout SHALL equal the final carry, and ovf SHALL be (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the registered (possibly inverted) operand.
REQ-023 In DONE, sum, cout and ovf SHALL hold stable until out_ready=1; out_valid && out_ready SHALL return the FSM to IDLE on that edge.
REQ-024 Operand input changes after acceptance SHALL have no effect; in_valid in ADD or DONE SHALL be ignored, and no operand set SHALL be lost or double-accepted.
REQ-025 No input-to-output combinational path: in_ready and out_valid SHALL depend on state only, and the earliest re-acceptance SHALL be the cycle after the output transfer.
REQ-026 sum, cout and ovf SHALL be don't-care while out_valid=0, but SHALL be deterministic (register contents).
REQ-027 Arithmetic SHALL be modulo 2^WIDTH; bits above WIDTH SHALL appear only in cout.

Reset
REQ-028 rst=1 SHALL, on the next edge regardless of state, force IDLE, chunk counter 0, carry 0, and sum 0, and SHALL clear cout, ovf and out_valid to 0 and set in_ready to 1 after reset deasserts.
REQ-029 Reset in ADD or DONE SHALL abort the operation; no out_valid SHALL be produced for it.
REQ-030 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-031 Add with wrap: accept a=0xFFFF, b=0x0001, sub=0, cin=0 at edge T -> out_valid at T+4; sum=0x0000, cout=1, ovf=0.
REQ-032 Signed overflow: a=0x7FFF, b=0x0001, sub=0, cin=1 -> sum=0x8001, cout=0, ovf=1.
REQ-033 Subtract: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1; a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-034 Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling a, b and in_valid -> sum, cout and ovf are unchanged, in_ready=0, and exactly one transfer occurs when out_ready=1.
REQ-035 Reset mid-op: accept, then assert rst in the 2nd ADD cycle -> the next cycle shows in_ready=1, out_valid=0, sum=0, and no result is ever emitted; a new add 0x1234+0x1111 then gives 0x2345.
REQ-036 Random: 1000 random operands and modes with random in_valid/out_ready -> every result matches the reference model, and the accept-to-out_valid delay is always N+1 cycles.
